stream_mux: RTL
===============

STREAM_MUX -- requirements
Module: stream_mux

Interface
REQ-001 Parameter: WIDTH, 8, data bits per channel (>=1).
REQ-002 Parameter: NCH, 4, number of input channels (>=2); SELW = max(1, clog2(NCH)), derived, not overridable.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port: in_data  input  NCH*WIDTH  channel i data at bits [i*WIDTH +: WIDTH].
REQ-006 Port: in_valid  input  NCH  channel i offers a word.
REQ-007 Port: in_ready  output  NCH  channel i word accepted this cycle.
REQ-008 Port: mode  input  1  0 = fixed select, 1 = round-robin.
REQ-009 Port: sel  input  SELW  channel index used in fixed mode.
REQ-010 Port: out_data  output  WIDTH  registered selected word.
REQ-011 Port: out_ch  output  SELW  source channel index of out_data.
REQ-012 Port: out_valid  output  1  out_data/out_ch hold a word.
REQ-013 Port: out_ready  input  1  downstream accepts the word this cycle.

Function
REQ-014 Transfer: a handshake occurs on a port when valid and ready are both high at a rising clk edge.
REQ-015 Load enable: load_en = !out_valid || out_ready; the output register may take a new word only when load_en is high.
REQ-016 Fixed mode: grant to channel sel when sel < NCH and in_valid[sel] = 1; otherwise no grant; all other channels are ignored.
REQ-017 Fixed mode: sel >= NCH (NCH not a power of two) yields no grant, and no in_ready is asserted.
REQ-018 Round-robin mode: grant to the first channel with in_valid = 1, searching ptr+1, ptr+2, ... modulo NCH; ptr is searched last.
REQ-019 ptr: SELW-bit register; on every accepted word in round-robin mode, ptr is set to the granted index; it is unchanged in fixed mode.
REQ-020 in_ready[i] = load_en && a grant exists && grant index == i; at most one in_ready bit is high in any cycle.
REQ-021 in_ready is combinational from in_valid, mode, sel, ptr, out_valid and out_ready; in_ready does not depend on in_data.
REQ-022 On an accepted word: out_data <= selected in_data; out_ch <= grant index; out_valid <= 1.
REQ-023 Latency: a word accepted at edge N appears on out_data with out_valid = 1 after edge N; minimum latency is 1 cycle.
REQ-024 Throughput: 1 word per cycle when out_ready is held high; a simultaneous drain and load in the same cycle is required and shall not insert a bubble.
REQ-025 On a drain with no grant (out_valid && out_ready, no grant): out_valid <= 0; out_data and out_ch hold their last values.
REQ-026 Backpressure: while out_valid && !out_ready, out_data, out_ch and out_valid shall stay stable and all in_ready bits shall be 0.
REQ-027 A change of mode or sel affects only the next grant decision; a word already held in the output register is unaffected.
REQ-028 Switching from fixed mode to round-robin mode uses the current ptr value, which is not reset by the switch.
REQ-029 No word is lost or duplicated: every input handshake produces exactly one output handshake, in acceptance order.

Reset
REQ-030 While rst_n = 0 at a rising edge: out_valid <= 0, out_data <= 0, out_ch <= 0, ptr <= NCH-1, so the first round-robin search starts at channel 0.
REQ-031 During a reset cycle all in_ready bits shall be 0.
REQ-032 Reset mid-transfer: a held word is discarded without an output handshake.
REQ-033 The first grant is possible in the first cycle with rst_n = 1.

Verification
REQ-034 Fixed mode: mode=0, sel=2, in_valid=4'b1111, out_ready=1, data ch i = 8'hA0+i -> in_ready=4'b0100 every cycle; out_data=8'hA2, out_ch=2 continuously.
REQ-035 Round-robin after reset: mode=1, in_valid=4'b1111, out_ready=1 -> out_ch sequence 0,1,2,3,0,... with one word per cycle.
REQ-036 Round-robin skip: in_valid=4'b1010, ptr=1 -> grants 3,1,3,1; ch0 and ch2 never receive in_ready.
REQ-037 Backpressure: word held, out_ready=0 for 5 cycles -> out_data/out_ch stable, in_ready=0; out_ready=1 -> drain and a new load occur in the same cycle.
REQ-038 Invalid sel: NCH=3, mode=0, sel=3, in_valid=3'b111 -> in_ready=0, out_valid remains 0.
REQ-039 Reset mid-stream: rst_n=0 for one cycle while out_valid=1 -> out_valid=0, out_data=0, out_ch=0; next round-robin grant goes to channel 0.

Source files
------------

// File: rtl/stream_mux.sv
// N-to-1 stream multiplexer with fixed-select and round-robin arbitration.
// Output is a single registered stage that can drain and reload in the same cycle.
module stream_mux #(
   parameter  int WIDTH = 8,
   parameter  int NCH   = 4,
   localparam int SELW  = (NCH > 2) ? $clog2(NCH) : 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NCH*WIDTH-1:0] in_data,
   input  logic [NCH-1:0]       in_valid,
   output logic [NCH-1:0]       in_ready,
   input  logic                 mode,
   input  logic [SELW-1:0]      sel,
   output logic [WIDTH-1:0]     out_data,
   output logic [SELW-1:0]      out_ch,
   output logic                 out_valid,
   input  logic                 out_ready
);

   logic [SELW-1:0]  r_ptr;
   logic [SELW-1:0]  r_out_ch;
   logic [WIDTH-1:0] r_out_data;
   logic             r_out_valid;

   logic             w_load_en;
   logic             w_fix_gnt;
   logic             w_rr_gnt;
   logic [SELW-1:0]  w_rr_idx;
   logic             w_gnt;
   logic [SELW-1:0]  w_gnt_idx;
   logic [WIDTH-1:0] w_sel_data;
   logic             w_accept;

   assign w_load_en = !r_out_valid || out_ready;

   // Out-of-range sel matches no channel, so it simply never grants.
   always_comb begin
      w_fix_gnt = 1'b0;
      for (int i = 0; i < NCH; i++)
         if (sel == SELW'(i) && in_valid[i]) w_fix_gnt = 1'b1;
   end

   // Search ptr+1 .. ptr+NCH; the last candidate is ptr itself.
   always_comb begin
      int idx;
      idx      = 0;
      w_rr_gnt = 1'b0;
      w_rr_idx = '0;
      for (int k = 1; k <= NCH; k++) begin
         idx = (int'(r_ptr) + k) % NCH;
         if (!w_rr_gnt && in_valid[idx]) begin
            w_rr_gnt = 1'b1;
            w_rr_idx = SELW'(idx);
         end
      end
   end

   assign w_gnt     = mode ? w_rr_gnt : w_fix_gnt;
   assign w_gnt_idx = mode ? w_rr_idx : sel;
   assign w_accept  = rst_n && w_load_en && w_gnt;

   always_comb begin
      w_sel_data = '0;
      for (int i = 0; i < NCH; i++)
         if (w_gnt_idx == SELW'(i)) w_sel_data = in_data[i*WIDTH +: WIDTH];
   end

   always_comb begin
      in_ready = '0;
      for (int i = 0; i < NCH; i++)
         in_ready[i] = w_accept && (w_gnt_idx == SELW'(i));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_ch    <= '0;
         r_ptr       <= SELW'(NCH - 1);
      end else if (w_accept) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_sel_data;
         r_out_ch    <= w_gnt_idx;
         if (mode) r_ptr <= w_gnt_idx;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_data  = r_out_data;
   assign out_ch    = r_out_ch;
   assign out_valid = r_out_valid;

endmodule
